dpu_pe: RTL and testbench
=========================

# dpu_pe

Parametrised systolic dot-product processing element, the next generation of the fixed 32-bit `dpu` cell. One `dpu_pe` multiplies a forwarded activation by a locally held weight and adds the partial sum arriving from its upstream neighbour. It is chained horizontally (x/valid) and vertically (y/valid) inside a systolic array. Relative to `dpu`, it adds:
- configurable widths and output latency;
- a double-buffered weight that can be reloaded while the array is streaming;
- valid tracking;
- a global stall;
- optional saturating accumulation.

## Interface
Parameters:
- DATA_W, 16, signed width of weight and activation.
- ACC_W, 40, signed width of partial sums; must be ≥ 2*DATA_W.
- Y_LAT, 2, number of y registers from the adder output to yout, inclusive; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  pipeline advance; 0 = stall of the x/y datapath.
- w_ld  in  1  load w_in into the shadow weight.
- w_in  in  DATA_W  signed weight input.
- w_swap  in  1  copy the shadow weight into the active weight.
- wout  out  DATA_W  current shadow weight, for daisy-chain loading.
- xin  in  DATA_W  signed activation.
- xin_vld  in  1  xin valid.
- xout  out  DATA_W  registered xin.
- xout_vld  out  1  registered xin_vld.
- yin  in  ACC_W  signed partial sum.
- yin_vld  in  1  yin valid.
- yout  out  ACC_W  signed partial sum out.
- yout_vld  out  1  yout valid.
- ovf  out  1  overflow flag, aligned with yout.

## Operation
- **x stage.** When en=1: x_z1 ← xin and xv_z1 ← xin_vld. xout = x_z1 and xout_vld = xv_z1.
- **Adder stage.** When en=1, the first y register is loaded with:
  - sum = sext(w_act × x_z1) + yin;
  - valid = xv_z1 & yin_vld.
- **y delay.** Further stages shift the sum, its valid and its ovf by Y_LAT−1 registers, each gated by en.
- **Arithmetic.**
  - The product is full-precision 2*DATA_W, sign-extended to ACC_W.
  - The add is performed at ACC_W+1 bits.
  - Truncation or saturation of the result is defined under Configuration.
- **Invalid data.** Data registers load regardless of valid; invalid slots carry don't-care data with valid=0.
- **Weights.**
  - w_sh and w_act are independent of en; weights can be loaded during a stall.
  - w_ld=1: w_sh ← w_in.
  - w_swap=1: w_act ← w_sh.
  - w_ld and w_swap in the same cycle: w_act gets the old w_sh, and w_sh gets w_in.
  - wout = w_sh.
- **Reset.** rst has priority over en. All registers clear: x_z1, all y stages, all valids, ovf, w_sh and w_act.
  - Reset values: xout=0, xout_vld=0, yout=0, yout_vld=0, ovf=0, wout=0.
  - A reset mid-stream discards all in-flight data; yout_vld stays 0 until new valid data traverses the pipe.

## Timing
- **xin to xout:** 1 cycle.
- **x to y alignment:**
  - xin is presented in cycle t.
  - The matching yin must be presented in cycle t+1.
  - yout and yout_vld appear in cycle t+1+Y_LAT, counting en=1 cycles only.
- **Weight use:** w_act is sampled at the adder edge. A w_swap asserted in cycle t affects sums computed in cycle t+1 onward; the sum at the cycle-t edge uses the old w_act.
- **Stall:** while en=0, all x/y data and valid outputs hold their values. No valid is lost or duplicated.
- **Throughput:** one result per en=1 cycle.
- **Reset:** takes effect at the next edge.

## Configuration
- **DPU_PE_SAT_EN defined.**
  - If the ACC_W+1-bit sum exceeds the ACC_W signed range, yout clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - ovf=1 for that result, registered and delayed with it.
  - A saturated yin propagates unchanged through the add.
- **DPU_PE_SAT_EN undefined.**
  - The sum wraps modulo 2^ACC_W.
  - ovf is tied to 0.

## Structure
- **Package dpu_pkg:**
  - default DATA_W, ACC_W and Y_LAT constants;
  - typedefs data_t and acc_t;
  - functions sat_acc() and sext_prod().
- **Sub-module dpu_dly:** a parametrised width × depth delay line with an enable and synchronous clear. It is instantiated for the y, valid and ovf chain of Y_LAT−1 stages; depth 0 is a passthrough.

## Test plan
Defaults unless noted (DATA_W=16, ACC_W=40, Y_LAT=2).
1. **Reset:** hold rst 3 cycles with random inputs → every output is 0, including wout and ovf.
2. **Basic product-sum:**
   - Stimulus: w_ld=1 with w_in=3, then w_swap=1; xin=5 with xin_vld=1 in cycle 0; yin=7 with yin_vld=1 in cycle 1.
   - Response: xout=5 in cycle 1; yout=22 with yout_vld=1 in cycle 3.
3. **Signed extremes:** w=−32768, x=−32768, yin=0 → yout=1073741824, ovf=0.
4. **Saturation at ACC_W=32:** w=32767, x=32767, yin=2147483647.
   - With DPU_PE_SAT_EN: yout=2147483647, ovf=1.
   - Without: yout=−1073807360, ovf=0.
5. **Stall:**
   - Stimulus: stream x=1,2,3,4 with w=2 and yin=0; drop en for 3 cycles after the second input.
   - Response: yout sequence 2,4,6,8 with no valid gaps or repeats in en=1 cycles; outputs hold during the stall.
6. **Weight swap and reset mid-stream:**
   - Stimulus: w_act=1, w_sh=4; pulse w_ld (w_in=9) and w_swap together during streaming.
   - Response: subsequent sums use 4 and wout=9. Then assert rst mid-stream → yout_vld=0 until new data arrives.

Source files
------------

// File: rtl/dpu_pe_pkg.sv
// Shared constants, types and arithmetic helpers for the dpu_pe systolic cell.
// Helpers work on the widest supported widths: DATA_W <= 32, ACC_W <= 64.
package dpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_Y_LAT  = 2;

  localparam int MAX_DATA_W = 32;
  localparam int MAX_ACC_W  = 64;

  typedef logic signed [DEF_DATA_W-1:0] data_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;
  typedef logic signed [MAX_ACC_W-1:0]  wide_acc_t;

  typedef struct packed {
    logic      ovf;
    wide_acc_t val;
  } sat_res_t;

  // Full-precision signed product, sign-extended to the widest accumulator.
  function automatic wide_acc_t sext_prod(input logic signed [MAX_DATA_W-1:0] w,
                                          input logic signed [MAX_DATA_W-1:0] x);
    return wide_acc_t'(w) * wide_acc_t'(x);
  endfunction

  // Clamp a one-bit-wider sum into the signed acc_w range and flag the clamp.
  function automatic sat_res_t sat_acc(input logic signed [MAX_ACC_W:0] sum,
                                       input int acc_w);
    logic signed [MAX_ACC_W:0] hi;
    logic signed [MAX_ACC_W:0] lo;
    sat_res_t r;
    hi = ((MAX_ACC_W+1)'(1) <<< (acc_w - 1)) - (MAX_ACC_W+1)'(1);
    lo = -hi - (MAX_ACC_W+1)'(1);
    r.ovf = 1'b0;
    r.val = wide_acc_t'(sum);
    if (sum > hi) begin
      r.val = wide_acc_t'(hi);
      r.ovf = 1'b1;
    end else if (sum < lo) begin
      r.val = wide_acc_t'(lo);
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpu_pe_if.sv
// Bundle of the dpu_pe weight-load, activation (x) and partial-sum (y) streams.
// Streams are valid-only: a slot advances on every clk edge with en=1; en is the sole backpressure.
interface dpu_pe_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic                     en;
  logic                     w_ld;
  logic signed [DATA_W-1:0] w_in;
  logic                     w_swap;
  logic signed [DATA_W-1:0] wout;
  logic signed [DATA_W-1:0] xin;
  logic                     xin_vld;
  logic signed [DATA_W-1:0] xout;
  logic                     xout_vld;
  logic signed [ACC_W-1:0]  yin;
  logic                     yin_vld;
  logic signed [ACC_W-1:0]  yout;
  logic                     yout_vld;
  logic                     ovf;

  modport master (
    output en, w_ld, w_in, w_swap, xin, xin_vld, yin, yin_vld,
    input  wout, xout, xout_vld, yout, yout_vld, ovf
  );

  modport slave (
    input  en, w_ld, w_in, w_swap, xin, xin_vld, yin, yin_vld,
    output wout, xout, xout_vld, yout, yout_vld, ovf
  );
endinterface

// File: rtl/dpu_pe_dly.sv
// dpu_dly: W-bit x DEPTH-stage delay line with enable and synchronous clear.
// DEPTH = 0 degenerates to a combinational passthrough.
module dpu_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, en};
    assign o_q = i_d;
  end else begin : g_pipe
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else if (en) begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_q = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/dpu_pe.sv
// dpu_pe: systolic multiply-accumulate cell with double-buffered weight and valid tracking.
// Optional feature macro DPU_PE_SAT_EN: saturating accumulate with overflow flag (default: wrap, ovf=0).
module dpu_pe
  import dpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int Y_LAT  = DEF_Y_LAT
) (
  input logic     clk,
  input logic     rst,
  dpu_pe_if.slave pe
);

  logic signed [DATA_W-1:0] r_w_sh;
  logic signed [DATA_W-1:0] r_w_act;
  logic signed [DATA_W-1:0] r_x_z1;
  logic                     r_xv_z1;
  logic signed [ACC_W-1:0]  r_y1;
  logic                     r_yv1;
  logic                     r_ovf1;

  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W:0]    w_sum;
  logic signed [ACC_W-1:0]  w_y;
  logic                     w_ovf;
  logic [ACC_W+1:0]         w_dly_q;

  // Weights ignore en so a new set can be shifted in while the array is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_sh  <= '0;
      r_w_act <= '0;
    end else begin
      if (pe.w_ld)   r_w_sh  <= pe.w_in;
      if (pe.w_swap) r_w_act <= r_w_sh;
    end
  end

  assign w_prod = ACC_W'(sext_prod(MAX_DATA_W'(r_w_act), MAX_DATA_W'(r_x_z1)));
  assign w_sum  = (ACC_W+1)'(w_prod) + (ACC_W+1)'(pe.yin);

`ifdef DPU_PE_SAT_EN
  sat_res_t w_sat;
  assign w_sat = sat_acc((MAX_ACC_W+1)'(w_sum), ACC_W);
  assign w_y   = ACC_W'(w_sat.val);
  assign w_ovf = w_sat.ovf;
`else
  assign w_y   = ACC_W'(w_sum);
  assign w_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_z1  <= '0;
      r_xv_z1 <= 1'b0;
      r_y1    <= '0;
      r_yv1   <= 1'b0;
      r_ovf1  <= 1'b0;
    end else if (pe.en) begin
      r_x_z1  <= pe.xin;
      r_xv_z1 <= pe.xin_vld;
      r_y1    <= w_y;
      r_yv1   <= r_xv_z1 & pe.yin_vld;
      r_ovf1  <= w_ovf;
    end
  end

  // Sum, valid and ovf travel together so they stay aligned for any Y_LAT.
  dpu_dly #(
    .W     (ACC_W + 2),
    .DEPTH (Y_LAT - 1)
  ) u_ydly (
    .clk (clk),
    .rst (rst),
    .en  (pe.en),
    .i_d ({r_ovf1, r_yv1, r_y1}),
    .o_q (w_dly_q)
  );

  assign pe.yout     = w_dly_q[ACC_W-1:0];
  assign pe.yout_vld = w_dly_q[ACC_W];
  assign pe.ovf      = w_dly_q[ACC_W+1];
  assign pe.xout     = r_x_z1;
  assign pe.xout_vld = r_xv_z1;
  assign pe.wout     = r_w_sh;

endmodule

// File: tb/tb_dpu_pe.sv
// Bench for dpu_pe: a default cell (ACC_W=40, Y_LAT=2) and a narrow cell (ACC_W=32, Y_LAT=1) share stimulus.
// Build with or without DPU_PE_SAT_EN; the reference model follows the same macro.
module tb_dpu_pe;
  import dpu_pkg::*;

  localparam int DW  = 16;
  localparam int AW0 = 40;
  localparam int YL0 = 2;
  localparam int AW1 = 32;
  localparam int YL1 = 1;
  localparam int E   = 81;   // {due[15:0], ovf, y[63:0]}
`ifdef DPU_PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     en, w_ld, w_swap, xin_vld, yin_vld;
  logic signed [DW-1:0]     w_in, xin;
  logic signed [63:0]       yin;

  dpu_pe_if #(.DATA_W(DW), .ACC_W(AW0)) if0 ();
  dpu_pe_if #(.DATA_W(DW), .ACC_W(AW1)) if1 ();

  assign if0.en = en;      assign if1.en = en;
  assign if0.w_ld = w_ld;  assign if1.w_ld = w_ld;
  assign if0.w_in = w_in;  assign if1.w_in = w_in;
  assign if0.w_swap = w_swap;   assign if1.w_swap = w_swap;
  assign if0.xin = xin;         assign if1.xin = xin;
  assign if0.xin_vld = xin_vld; assign if1.xin_vld = xin_vld;
  assign if0.yin = yin[AW0-1:0]; assign if1.yin = yin[AW1-1:0];
  assign if0.yin_vld = yin_vld; assign if1.yin_vld = yin_vld;

  dpu_pe #(.DATA_W(DW), .ACC_W(AW0), .Y_LAT(YL0)) dut0 (.clk(clk), .rst(rst), .pe(if0.slave));
  dpu_pe #(.DATA_W(DW), .ACC_W(AW1), .Y_LAT(YL1)) dut1 (.clk(clk), .rst(rst), .pe(if1.slave));

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: exact 64-bit sum, then clamp or wrap to aw bits.
  task automatic model_sum(input longint w, input longint x, input longint y, input int aw,
                           output longint r, output logic o);
    longint s, hi, lo;
    s  = w * x + y;
    hi = (64'sd1 <<< (aw - 1)) - 1;
    lo = -hi - 1;
    o  = 1'b0;
    if (SAT) begin
      r = s;
      if (s > hi) begin r = hi; o = 1'b1; end
      else if (s < lo) begin r = lo; o = 1'b1; end
    end else begin
      r = (s <<< (64 - aw)) >>> (64 - aw);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [E-1:0]       exp_q0[$];
  logic [E-1:0]       exp_q1[$];
  logic signed [63:0] cap_q[$];
  logic               cap_on = 1'b0;
  logic               chk_on = 1'b0;

  logic signed [DW-1:0] m_w_sh, m_w_act, m_x;
  logic                 m_xv;
  int                   adv_cnt = 0;
  logic                 last_adv = 1'b0;
  logic                 lv[2];
  logic signed [63:0]   ly[2];
  logic                 lo_[2];

  always @(posedge clk) begin
    longint r0, r1;
    logic   o0, o1;
    if (rst) begin
      m_w_sh = '0; m_w_act = '0; m_x = '0; m_xv = 1'b0;
      exp_q0.delete(); exp_q1.delete();
      last_adv = 1'b0;
      for (int d = 0; d < 2; d++) begin lv[d] = 1'b0; ly[d] = '0; lo_[d] = 1'b0; end
    end else begin
      if (en) begin
        adv_cnt++;
        if (m_xv && yin_vld) begin
          model_sum(longint'(m_w_act), longint'(m_x), longint'($signed(yin[AW0-1:0])), AW0, r0, o0);
          model_sum(longint'(m_w_act), longint'(m_x), longint'($signed(yin[AW1-1:0])), AW1, r1, o1);
          exp_q0.push_back({16'(adv_cnt + YL0 - 1), o0, r0});
          exp_q1.push_back({16'(adv_cnt + YL1 - 1), o1, r1});
        end
        m_x  = xin;
        m_xv = xin_vld;
      end
      last_adv = en;
      if (w_swap) m_w_act = m_w_sh;
      if (w_ld)   m_w_sh  = w_in;
    end
  end

  task automatic chk_y(input int d, input logic v, input logic signed [63:0] y, input logic o);
    logic [E-1:0] f;
    logic         have, ev;
    if (last_adv) begin
      have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      f = '0;
      if (have) f = (d == 0) ? exp_q0[0] : exp_q1[0];
      ev = have && (f[E-1 -: 16] == 16'(adv_cnt));
      check_eq($sformatf("yvld%0d", d), {63'd0, v}, {63'd0, ev});
      if (ev) begin
        if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        check_eq($sformatf("yout%0d", d), y, f[63:0]);
        check_eq($sformatf("ovf%0d", d), {63'd0, o}, {63'd0, f[64]});
        if (d == 0 && cap_on) cap_q.push_back(y);
        lv[d] = 1'b1; ly[d] = f[63:0]; lo_[d] = f[64];
      end else begin
        lv[d] = 1'b0;
      end
    end else begin
      check_eq($sformatf("hold_vld%0d", d), {63'd0, v}, {63'd0, lv[d]});
      if (lv[d]) begin
        check_eq($sformatf("hold_y%0d", d), y, ly[d]);
        check_eq($sformatf("hold_ovf%0d", d), {63'd0, o}, {63'd0, lo_[d]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("xout0", if0.xout, m_x);
      check_eq("xvld0", {63'd0, if0.xout_vld}, {63'd0, m_xv});
      check_eq("wout0", if0.wout, m_w_sh);
      check_eq("xout1", if1.xout, m_x);
      check_eq("wout1", if1.wout, m_w_sh);
      chk_y(0, if0.yout_vld, if0.yout, if0.ovf);
      chk_y(1, if1.yout_vld, if1.yout, if1.ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    en = 1'b1; w_ld = 1'b0; w_swap = 1'b0; xin_vld = 1'b0; yin_vld = 1'b0;
    w_in = DW'($urandom); xin = DW'($urandom); yin = {$urandom, $urandom};
  endtask

  task automatic rand_in();
    en = 1'($urandom_range(0, 1)); w_ld = 1'($urandom_range(0, 1));
    w_swap = 1'($urandom_range(0, 1)); xin_vld = 1'($urandom_range(0, 1));
    yin_vld = 1'($urandom_range(0, 1));
    w_in = DW'($urandom); xin = DW'($urandom); yin = {$urandom, $urandom};
  endtask

  task automatic load_w(input logic signed [DW-1:0] w);
    idle(); w_ld = 1'b1; w_in = w; @(negedge clk);
    idle(); w_swap = 1'b1; @(negedge clk);
  endtask

  // One product-sum: x in cycle 0, yin in cycle 1; sample narrow cell in cycle 2, default cell in cycle 3.
  task automatic pe_op(input logic signed [DW-1:0] w, input logic signed [DW-1:0] x,
                       input logic signed [63:0] y, output logic signed [63:0] xo,
                       output logic signed [63:0] y0, output logic o0, output logic v0,
                       output logic signed [63:0] y1, output logic o1, output logic v1);
    load_w(w);
    idle(); xin = x; xin_vld = 1'b1; @(negedge clk);
    xo = if0.xout;
    idle(); yin = y; yin_vld = 1'b1; @(negedge clk);
    y1 = if1.yout; o1 = if1.ovf; v1 = if1.yout_vld;
    idle(); @(negedge clk);
    y0 = if0.yout; o0 = if0.ovf; v0 = if0.yout_vld;
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic signed [63:0] xo, y0, y1;
    logic               o0, o1, v0, v1;

    rst = 1'b1;
    repeat (3) begin rand_in(); @(negedge clk); end
    check_eq("rst_xout",  if0.xout, 0);
    check_eq("rst_xvld",  {63'd0, if0.xout_vld}, 0);
    check_eq("rst_yout",  if0.yout, 0);
    check_eq("rst_yvld",  {63'd0, if0.yout_vld}, 0);
    check_eq("rst_ovf",   {63'd0, if0.ovf}, 0);
    check_eq("rst_wout",  if0.wout, 0);
    check_eq("rst_yout1", if1.yout, 0);
    chk_on = 1'b1;
    rst = 1'b0;
    idle(); @(negedge clk);

    // basic product-sum
    pe_op(16'sd3, 16'sd5, 64'sd7, xo, y0, o0, v0, y1, o1, v1);
    check_eq("basic_xout", xo, 5);
    check_eq("basic_y0", y0, 22);
    check_eq("basic_v0", {63'd0, v0}, 1);
    check_eq("basic_y1", y1, 22);

    // signed extremes
    pe_op(-16'sd32768, -16'sd32768, 64'sd0, xo, y0, o0, v0, y1, o1, v1);
    check_eq("ext_y0", y0, 64'sd1073741824);
    check_eq("ext_ovf0", {63'd0, o0}, 0);
    check_eq("ext_y1", y1, 64'sd1073741824);
    check_eq("ext_ovf1", {63'd0, o1}, 0);

    // overflow of the 32-bit accumulator
    pe_op(16'sd32767, 16'sd32767, 64'sd2147483647, xo, y0, o0, v0, y1, o1, v1);
    check_eq("sat_y1", y1, SAT ? 64'sd2147483647 : -64'sd1073807360);
    check_eq("sat_ovf1", {63'd0, o1}, SAT ? 64'sd1 : 64'sd0);
    check_eq("sat_v1", {63'd0, v1}, 1);
    check_eq("sat_y0", y0, 64'sd3221159936);
    check_eq("sat_ovf0", {63'd0, o0}, 0);

    // stall after the second activation
    load_w(16'sd2);
    cap_on = 1'b1;
    for (int s = 0; s < 6; s++) begin
      idle();
      if (s < 4) begin xin = DW'(s + 1); xin_vld = 1'b1; end
      if (s >= 1 && s <= 4) begin yin = 0; yin_vld = 1'b1; end
      @(negedge clk);
      if (s == 1) begin
        repeat (3) begin
          idle(); en = 1'b0;
          xin_vld = 1'($urandom_range(0, 1)); yin_vld = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
    end
    idle(); repeat (3) @(negedge clk);
    cap_on = 1'b0;
    check_eq("stall_cnt", cap_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic signed [63:0] got;
      got = (i < cap_q.size()) ? cap_q[i] : 64'sd0;
      check_eq($sformatf("stall_y%0d", i), got, 2 * (i + 1));
    end

    // swap with concurrent load, then reset mid-stream
    load_w(16'sd1);
    idle(); w_ld = 1'b1; w_in = 16'sd4; @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      idle(); xin_vld = 1'b1; yin = 64'($urandom_range(0, 1000)); yin_vld = 1'b1;
      if (i == 3) begin w_ld = 1'b1; w_in = 16'sd9; w_swap = 1'b1; end
      @(negedge clk);
      if (i == 4) check_eq("swap_wout", if0.wout, 9);
    end
    idle(); xin_vld = 1'b1; yin_vld = 1'b1; rst = 1'b1; @(negedge clk);
    check_eq("mrst_vld0", {63'd0, if0.yout_vld}, 0);
    check_eq("mrst_vld1", {63'd0, if1.yout_vld}, 0);
    rst = 1'b0;
    idle(); xin_vld = 1'b1; yin_vld = 1'b1; @(negedge clk);
    check_eq("mrst_vld0b", {63'd0, if0.yout_vld}, 0);
    for (int i = 0; i < 4; i++) begin
      idle(); xin_vld = 1'b1; yin_vld = 1'b1; @(negedge clk);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_in();
      if ($urandom_range(0, 3) != 0) en = 1'b1;
      rst = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    idle(); repeat (4) @(negedge clk);
    check_eq("drain_q0", exp_q0.size(), 0);
    check_eq("drain_q1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
